mul_share_arbiter: RTL and testbench

Shares one sequential shift-add WIDTH x WIDTH multiplier among NREQ requesters.
- Round-robin arbitration with valid/ready handshakes on every request port and on the single response port.
- Each response is tagged with the index of the requester it belongs to.
- Sits between the tile's input-decode logic and the product output register, replacing per-requester combinational multipliers.

---
 rtl/mul_share_pkg.sv | 26 ++
 rtl/mul_shift_add.sv | 50 +++++
 rtl/mul_share_arbiter.sv | 108 ++++++++++
 tb/tb_mul_share_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// Shared types and the round-robin grant helper for the shared multiplier arbiter.
package mul_share_pkg;

  localparam int unsigned MaxReq = 8;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StResp
  } state_e;

  // First set bit of valid at or above ptr, wrapping at nreq-1; -1 when none is set.
  function automatic int rr_grant(input logic [MaxReq-1:0] valid, input int unsigned nreq,
                                  input int unsigned ptr);
    int          g;
    int unsigned j;
    g = -1;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      j = ptr + k;
      if (j >= nreq) j = j - nreq;
      if (k < nreq && g < 0 && valid[j[2:0]]) g = int'(j);
    end
    return g;
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Sequential shift-add multiplier: one partial-product step per enabled cycle.
module mul_shift_add #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               ena,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [CW-1:0]      cnt_q;
  logic               run_q;
  logic               last;

  assign last    = (cnt_q == CW'(WIDTH - 1));
  // Product is the accumulator after the current step, so it is valid in the done cycle.
  assign product = acc_q + (b_sh_q[0] ? a_sh_q : '0);
  assign done    = run_q && ena && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else if (start) begin
      acc_q  <= '0;
      a_sh_q <= {{WIDTH{1'b0}}, a};
      b_sh_q <= b;
      cnt_q  <= '0;
      run_q  <= 1'b1;
    end else if (run_q && ena) begin
      acc_q  <= product;
      a_sh_q <= a_sh_q << 1;
      b_sh_q <= b_sh_q >> 1;
      cnt_q  <= cnt_q + 1'b1;
      if (last) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier among NREQ valid/ready requesters.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter  int unsigned NREQ  = 4,
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_product,
  output logic                  busy
);

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [2*WIDTH-1:0] rsp_product_q, rsp_product_d;

  int                 gnt;
  logic               gnt_found;
  logic [IDW-1:0]     gnt_idx;
  logic               accept;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign gnt       = rr_grant(MaxReq'(req_valid), NREQ, 32'(ptr_q));
  assign gnt_found = (gnt >= 0);
  assign gnt_idx   = IDW'(gnt);

  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && ena && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign accept      = |(req_valid & req_ready);
  assign rsp_valid   = (state_q == StResp);
  assign busy        = (state_q != StIdle);
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;

  mul_shift_add #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept),
    .a      (req_a[gnt_idx*WIDTH +: WIDTH]),
    .b      (req_b[gnt_idx*WIDTH +: WIDTH]),
    .ena    (ena),
    .done   (mul_done),
    .product(mul_product)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StMul;
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      StMul: begin
        if (mul_done) begin
          state_d       = StResp;
          rsp_id_d      = id_q;
          rsp_product_d = mul_product;
        end
      end
      StResp: begin
        if (ena && rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      id_q          <= '0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized and directed bench for mul_share_arbiter against a transaction-level model.
module tb_mul_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic                  ena;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_product;
  logic                  busy;

  mul_share_arbiter #(
    .NREQ (NREQ),
    .WIDTH(WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_product(rsp_product),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec, n_err, cyc, accepted;
  // Model: phase 0 idle, 1 computing (m_left cycles to go), 2 response pending.
  int m_phase, m_left, m_ptr, m_id, m_prod, m_rsp_id, m_rsp_prod;
  int cap_id[$], cap_prod[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_ptr = 0; m_id = 0; m_prod = 0;
    m_rsp_id = 0; m_rsp_prod = 0; accepted = -1;
  endtask

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Called just after inputs are driven on a falling edge; returns on the next falling edge.
  task automatic step();
    int g;
    logic [NREQ-1:0] er;
    #1;
    g  = model_grant();
    er = '0;
    if (m_phase == 0 && ena && g >= 0) er[g] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(er));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
    check_eq("busy", 32'(busy), 32'(m_phase != 0));
    check_eq("rsp_id", 32'(rsp_id), m_rsp_id);
    check_eq("rsp_product", 32'(rsp_product), m_rsp_prod);
    if (rsp_valid && rsp_ready && ena) begin
      cap_id.push_back(int'(rsp_id));
      cap_prod.push_back(int'(rsp_product));
    end
    @(posedge clk);
    cyc++;
    accepted = -1;
    if (ena) begin
      case (m_phase)
        0: if (g >= 0) begin
          m_phase  = 1;
          m_left   = WIDTH;
          m_id     = g;
          m_prod   = int'(req_a[g*WIDTH +: WIDTH]) * int'(req_b[g*WIDTH +: WIDTH]);
          m_ptr    = (g + 1) % NREQ;
          accepted = g;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 2; m_rsp_id = m_id; m_rsp_prod = m_prod;
          end
        end
        default: if (rsp_ready) m_phase = 0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input int a, input int b);
    req_valid[i]             = v;
    req_a[i*WIDTH +: WIDTH]  = WIDTH'(a);
    req_b[i*WIDTH +: WIDTH]  = WIDTH'(b);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_rsp_product", 32'(rsp_product), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int guard;
    req_valid = '0; ena = 1'b1; rsp_ready = 1'b1; guard = 0;
    while (m_phase != 0 && guard < 30) begin step(); guard++; end
    check_eq("drain_idle", 32'(m_phase), 0);
  endtask

  // Steps until the DUT shows a response; returns cycles elapsed since t0.
  task automatic wait_rsp(input int t0, output int lat);
    int guard;
    guard = 0;
    while (!rsp_valid && guard < 30) begin step(); guard++; end
    lat = cyc - t0;
  endtask

  initial begin
    int t0, lat;
    int exp_id[5], exp_prod[5];
    n_vec = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0; ena = 1'b1; rsp_ready = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0;
    model_reset();
    #12;
    check_eq("reset_rsp_valid", 32'(rsp_valid), 0);
    check_eq("reset_busy", 32'(busy), 0);
    check_eq("reset_rsp_id", 32'(rsp_id), 0);
    check_eq("reset_rsp_product", 32'(rsp_product), 0);
    check_eq("reset_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester 0: 3*5, 4 cycles of latency.
    set_req(0, 1'b1, 3, 5);
    step();
    check_eq("t1_accept", accepted, 0);
    req_valid = '0;
    t0 = cyc;
    wait_rsp(t0, lat);
    check_eq("t1_latency", lat, 4);
    check_eq("t1_product", 32'(rsp_product), 15);
    drain();

    // All four continuously valid, starting from pointer 0.
    async_reset();
    cap_id.delete(); cap_prod.delete();
    set_req(0, 1'b1, 2, 3);  set_req(1, 1'b1, 4, 5);
    set_req(2, 1'b1, 6, 7);  set_req(3, 1'b1, 15, 15);
    exp_id   = '{0, 1, 2, 3, 0};
    exp_prod = '{6, 20, 42, 225, 6};
    for (int c = 0; c < 60 && cap_id.size() < 5; c++) step();
    check_eq("t2_count", cap_id.size(), 5);
    for (int k = 0; k < 5 && k < cap_id.size(); k++) begin
      check_eq("t2_id", cap_id[k], exp_id[k]);
      check_eq("t2_product", cap_prod[k], exp_prod[k]);
    end
    drain();

    // Response back-pressure for 10 cycles; the model checks stability every cycle.
    async_reset();
    set_req(0, 1'b1, 11, 13);
    rsp_ready = 1'b0;
    step();
    req_valid = '0;
    wait_rsp(cyc, lat);
    for (int c = 0; c < 10; c++) step();
    check_eq("t3_held", 32'(rsp_product), 143);
    rsp_ready = 1'b1;
    step();
    check_eq("t3_released", 32'(rsp_valid), 0);

    // Enable dropped for 3 cycles mid-multiply (requester 1 leaves pointer at 2).
    set_req(1, 1'b1, 9, 7);
    step();
    check_eq("t4_accept", accepted, 1);
    req_valid = '0;
    t0 = cyc;
    step();
    ena = 1'b0;
    for (int c = 0; c < 3; c++) step();
    ena = 1'b1;
    wait_rsp(t0, lat);
    check_eq("t4_latency", lat, 7);
    check_eq("t4_product", 32'(rsp_product), 63);
    drain();

    // Pointer at 2, requests from 1 and 3: 3 is served first; zero operands.
    cap_id.delete(); cap_prod.delete();
    set_req(1, 1'b1, 0, 9);
    set_req(3, 1'b1, 12, 0);
    for (int c = 0; c < 30 && cap_id.size() < 2; c++) begin
      step();
      if (accepted >= 0) req_valid[accepted] = 1'b0;
    end
    check_eq("t5_count", cap_id.size(), 2);
    if (cap_id.size() >= 2) begin
      check_eq("t5_first_id", cap_id[0], 3);
      check_eq("t5_second_id", cap_id[1], 1);
      check_eq("t5_prod0", cap_prod[0], 0);
      check_eq("t5_prod1", cap_prod[1], 0);
    end
    drain();

    // Reset mid-multiply and mid-response, then requester 1 alone.
    set_req(2, 1'b1, 5, 5);
    step();
    req_valid = '0;
    step();
    async_reset();
    set_req(2, 1'b1, 5, 6);
    rsp_ready = 1'b0;
    step();
    req_valid = '0;
    wait_rsp(cyc, lat);
    async_reset();
    cap_id.delete(); cap_prod.delete();
    rsp_ready = 1'b1;
    set_req(1, 1'b1, 13, 11);
    step();
    check_eq("t6_accept", accepted, 1);
    req_valid = '0;
    wait_rsp(cyc, lat);
    step();
    check_eq("t6_count", cap_id.size(), 1);
    if (cap_id.size() >= 1) begin
      check_eq("t6_id", cap_id[0], 1);
      check_eq("t6_product", cap_prod[0], 143);
    end
    drain();

    // Random traffic: requests hold operands until accepted or withdrawn.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        logic was;
        was = req_valid[i];
        if (was && accepted == i) req_valid[i] = 1'b0;
        else if (was && $urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
        if ((!was || accepted == i) && $urandom_range(0, 2) == 0)
          set_req(i, 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      end
      ena       = ($urandom_range(0, 9) != 0);
      rsp_ready = $urandom_range(0, 1) != 0;
      step();
      if ($urandom_range(0, 299) == 0) async_reset();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
